i2c_arbiter: RTL and testbench



---
 rtl/i2c_arbiter_if.sv | 31 +++
 rtl/i2c_arbiter.sv | 163 ++++++++++++++++
 tb/tb_i2c_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the shared i2c_controller.
// slave is the arbiter's view; master is the requester/controller side.
interface i2c_arbiter_if;
   logic [1:0]  req;
   logic [1:0]  req_mode;
   logic [13:0] req_addr;
   logic [15:0] req_byte;
   logic [1:0]  gnt;
   logic [1:0]  done;
   logic [7:0]  rx_byte;
   logic        timeout_err;
   logic        busy;
   logic        i2c_enable;
   logic        i2c_mode;
   logic [6:0]  i2c_periph_addr;
   logic [7:0]  i2c_transmit_byte;
   logic [3:0]  i2c_state;
   logic [7:0]  i2c_byte_reg;

   modport slave (
      input  req, req_mode, req_addr, req_byte, i2c_state, i2c_byte_reg,
      output gnt, done, rx_byte, timeout_err, busy,
             i2c_enable, i2c_mode, i2c_periph_addr, i2c_transmit_byte
   );

   modport master (
      output req, req_mode, req_addr, req_byte, i2c_state, i2c_byte_reg,
      input  gnt, done, rx_byte, timeout_err, busy,
             i2c_enable, i2c_mode, i2c_periph_addr, i2c_transmit_byte
   );
endinterface

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2c_controller between two requesters,
// with command latching, enable/state handshake sequencing and per-phase timeout.
module i2c_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned CNT_W          = 12
) (
   input logic          clk,
   input logic          reset,
   i2c_arbiter_if.slave bus
);
   localparam int unsigned N_REQ  = 2;
   localparam int unsigned ADDR_W = 7;
   localparam int unsigned DATA_W = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_DONE} state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic                last_served, last_served_nxt;
   logic [N_REQ-1:0]    gnt_q, gnt_nxt;
   logic [N_REQ-1:0]    done_q, done_nxt;
   logic [DATA_W-1:0]   rx_q, rx_nxt;
   logic                terr_q, terr_nxt;
   logic                busy_q, busy_nxt;
   logic                en_q, en_nxt;
   logic                mode_q, mode_nxt;
   logic [ADDR_W-1:0]   addr_q, addr_nxt;
   logic [DATA_W-1:0]   tx_q, tx_nxt;

   logic                pick_vld;
   logic                pick_idx;
   logic                ctl_active;
   logic                tmo;

   // Round-robin pick: a tie goes to the requester that was not served last.
   always_comb begin
      pick_vld = |bus.req;
      case (bus.req)
         2'b01:   pick_idx = 1'b0;
         2'b10:   pick_idx = 1'b1;
         2'b11:   pick_idx = ~last_served;
         default: pick_idx = 1'b0;
      endcase
   end

   assign ctl_active = (bus.i2c_state != 4'd0);
   assign tmo        = (cnt == CNT_LAST);

   // State register and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         last_served <= 1'b1;
         gnt_q       <= '0;
         done_q      <= '0;
         rx_q        <= '0;
         terr_q      <= 1'b0;
         busy_q      <= 1'b0;
         en_q        <= 1'b0;
         mode_q      <= 1'b0;
         addr_q      <= '0;
         tx_q        <= '0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         last_served <= last_served_nxt;
         gnt_q       <= gnt_nxt;
         done_q      <= done_nxt;
         rx_q        <= rx_nxt;
         terr_q      <= terr_nxt;
         busy_q      <= busy_nxt;
         en_q        <= en_nxt;
         mode_q      <= mode_nxt;
         addr_q      <= addr_nxt;
         tx_q        <= tx_nxt;
      end
   end

   // Next-state logic; the controller's exit condition wins over a same-cycle timeout.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (pick_vld) state_nxt = S_LAUNCH;
         S_LAUNCH: begin
            if (ctl_active)  state_nxt = S_RUN;
            else if (tmo)    state_nxt = S_DONE;
         end
         S_RUN:    if (!ctl_active || tmo) state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Next values of the registered outputs, counter and round-robin pointer.
   always_comb begin
      cnt_nxt         = cnt;
      last_served_nxt = last_served;
      gnt_nxt         = gnt_q;
      done_nxt        = done_q;
      rx_nxt          = rx_q;
      terr_nxt        = terr_q;
      en_nxt          = en_q;
      mode_nxt        = mode_q;
      addr_nxt        = addr_q;
      tx_nxt          = tx_q;
      busy_nxt        = (state_nxt != S_IDLE);

      case (state)
         S_IDLE: begin
            if (pick_vld) begin
               gnt_nxt  = pick_idx ? 2'b10 : 2'b01;
               en_nxt   = 1'b1;
               mode_nxt = bus.req_mode[pick_idx];
               addr_nxt = pick_idx ? bus.req_addr[13:7] : bus.req_addr[6:0];
               tx_nxt   = pick_idx ? bus.req_byte[15:8] : bus.req_byte[7:0];
               cnt_nxt  = '0;
            end
         end
         S_LAUNCH: begin
            if (ctl_active) begin
               en_nxt  = 1'b0;
               cnt_nxt = '0;
            end else if (tmo) begin
               en_nxt   = 1'b0;
               done_nxt = gnt_q;
               terr_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_RUN: begin
            if (!ctl_active) begin
               rx_nxt   = bus.i2c_byte_reg;
               done_nxt = gnt_q;
            end else if (tmo) begin
               done_nxt = gnt_q;
               terr_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_DONE: begin
            done_nxt        = '0;
            gnt_nxt         = '0;
            terr_nxt        = 1'b0;
            last_served_nxt = gnt_q[1];
         end
         default: ;
      endcase
   end

   assign bus.gnt               = gnt_q;
   assign bus.done              = done_q;
   assign bus.rx_byte           = rx_q;
   assign bus.timeout_err       = terr_q;
   assign bus.busy              = busy_q;
   assign bus.i2c_enable        = en_q;
   assign bus.i2c_mode          = mode_q;
   assign bus.i2c_periph_addr   = addr_q;
   assign bus.i2c_transmit_byte = tx_q;
endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter: directed scenarios plus randomized
// transactions against a latency/round-robin reference model.
`timescale 1ns/1ps
module tb_i2c_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   i2c_arbiter_if bus ();
   i2c_arbiter_if tbus ();

   i2c_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
   i2c_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(4)) dut_to (.clk(clk), .reset(reset), .bus(tbus));

   int n_cmp = 0;
   int n_bad = 0;
   bit last  = 1'b1;   // requester served most recently, per the round-robin rule

   // Controller model: leaves IDLE m_l cycles after seeing enable, returns m_r cycles later.
   int unsigned m_l  = 4;
   int unsigned m_r  = 40;
   logic [7:0]  m_rx = 8'h00;
   int unsigned m_cnt = 0;
   bit          m_run = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         bus.i2c_state = 4'd0;
         m_cnt = 0;
         m_run = 1'b0;
      end else if (!m_run) begin
         if (bus.i2c_enable) begin
            m_cnt++;
            if (m_cnt >= m_l) begin
               bus.i2c_state = 4'd5;
               m_run = 1'b1;
               m_cnt = 0;
            end
         end else begin
            m_cnt = 0;
         end
      end else begin
         m_cnt++;
         if (m_cnt >= m_r) begin
            bus.i2c_byte_reg = m_rx;
            bus.i2c_state = 4'd0;
            m_run = 1'b0;
            m_cnt = 0;
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1;
      bus.req = '0; bus.req_mode = '0; bus.req_addr = '0; bus.req_byte = '0;
      tbus.req = '0; tbus.req_mode = '0; tbus.req_addr = '0; tbus.req_byte = '0;
      tbus.i2c_state = 4'd0; tbus.i2c_byte_reg = 8'h5A;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({bus.gnt, bus.done, bus.rx_byte, bus.timeout_err, bus.busy, bus.i2c_enable,
           bus.i2c_mode, bus.i2c_periph_addr, bus.i2c_transmit_byte} !== 38'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got gnt=%b done=%b rx=%h terr=%b busy=%b en=%b, required all 0",
                  bus.gnt, bus.done, bus.rx_byte, bus.timeout_err, bus.busy, bus.i2c_enable);
      end
      n_cmp++;
      if ({tbus.gnt, tbus.done, tbus.rx_byte, tbus.timeout_err, tbus.busy, tbus.i2c_enable} !== 22'd0) begin
         n_bad++;
         $display("FAIL reset_outputs_to: got gnt=%b done=%b busy=%b en=%b, required all 0",
                  tbus.gnt, tbus.done, tbus.busy, tbus.i2c_enable);
      end
      reset = 1'b0;
      last = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.busy !== 1'b0 || bus.gnt !== 2'b00) begin
         n_bad++;
         $display("FAIL idle_after_reset: got busy=%b gnt=%b, required 0/00", bus.busy, bus.gnt);
      end
   endtask

   task automatic test_single_write();
      int done_cnt = 0;
      int done_k = -1;
      bit bad_en = 0, bad_gnt = 0, bad_fld = 0, bad_busy = 0, seen_terr = 0;
      m_l = 4; m_r = 40; m_rx = 8'h00;
      bus.req = 2'b01; bus.req_mode = 2'b01;
      bus.req_addr = {7'h00, 7'h1A}; bus.req_byte = {8'h00, 8'h5C};
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (k == 0) bus.req = 2'b00;
         if (bus.i2c_enable !== (k < 4)) bad_en = 1;
         if (bus.gnt !== ((k <= 44) ? 2'b01 : 2'b00)) bad_gnt = 1;
         if (bus.busy !== (k <= 44)) bad_busy = 1;
         if (bus.i2c_periph_addr !== 7'h1A || bus.i2c_transmit_byte !== 8'h5C || bus.i2c_mode !== 1'b1) bad_fld = 1;
         if (bus.done == 2'b01) begin done_cnt++; done_k = k; end
         if (bus.timeout_err !== 1'b0) seen_terr = 1;
      end
      n_cmp++; if (bad_en)   begin n_bad++; $display("FAIL write_enable: got enable outside cycles 0..3, required LAUNCH only"); end
      n_cmp++; if (bad_gnt)  begin n_bad++; $display("FAIL write_gnt: got gnt off 01 during transaction, required 01 through done"); end
      n_cmp++; if (bad_busy) begin n_bad++; $display("FAIL write_busy: got busy wrong, required high cycles 0..44"); end
      n_cmp++; if (bad_fld)  begin n_bad++; $display("FAIL write_fields: got addr=%h tx=%h mode=%b, required 1a/5c/1",
                                                     bus.i2c_periph_addr, bus.i2c_transmit_byte, bus.i2c_mode); end
      n_cmp++; if (done_cnt != 1 || done_k != 44) begin n_bad++;
         $display("FAIL write_done: got %0d pulses last at %0d, required 1 at 44", done_cnt, done_k); end
      n_cmp++; if (seen_terr) begin n_bad++; $display("FAIL write_terr: got timeout_err=1, required 0"); end
      last = 1'b0;
   endtask

   task automatic test_read();
      int k;
      m_l = 3; m_r = 10; m_rx = 8'hA7;
      bus.req = 2'b10; bus.req_mode = 2'b00;
      bus.req_addr = {7'h48, 7'h11}; bus.req_byte = 16'h0000;
      for (k = 0; k < 40; k++) begin
         @(negedge clk);
         if (k == 0) bus.req = 2'b00;
         if (bus.done !== 2'b00) break;
      end
      n_cmp++;
      if (k != 13 || bus.done !== 2'b10) begin n_bad++;
         $display("FAIL read_done: got done=%b at %0d, required 10 at 13", bus.done, k); end
      n_cmp++;
      if (bus.rx_byte !== 8'hA7 || bus.i2c_mode !== 1'b0 || bus.i2c_periph_addr !== 7'h48) begin n_bad++;
         $display("FAIL read_data: got rx=%h mode=%b addr=%h, required a7/0/48",
                  bus.rx_byte, bus.i2c_mode, bus.i2c_periph_addr); end
      @(negedge clk);
      last = 1'b1;
   endtask

   task automatic test_latching();
      int k;
      bit bad_tx = 0;
      m_l = 2; m_r = 6; m_rx = 8'h00;
      bus.req = 2'b01; bus.req_mode = 2'b01;
      bus.req_addr = {7'h00, 7'h22}; bus.req_byte = {8'h00, 8'h33};
      for (k = 0; k < 30; k++) begin
         @(negedge clk);
         if (k == 1) begin bus.req_byte[7:0] = 8'hFF; bus.req = 2'b00; bus.req_addr = 14'h3FFF; end
         if (bus.i2c_transmit_byte !== 8'h33 || bus.i2c_periph_addr !== 7'h22) bad_tx = 1;
         if (bus.done !== 2'b00) break;
      end
      n_cmp++;
      if (bad_tx) begin n_bad++;
         $display("FAIL latch_tx: got tx=%h addr=%h, required 33/22", bus.i2c_transmit_byte, bus.i2c_periph_addr); end
      n_cmp++;
      if (bus.done !== 2'b01 || k != 8) begin n_bad++;
         $display("FAIL latch_done: got done=%b at %0d, required 01 at 8", bus.done, k); end
      @(negedge clk);
      last = 1'b0;
   endtask

   // req=11 held: period is L+R (=7) transaction cycles + DONE-exit idle cycle + grant edge = 9.
   task automatic test_tie();
      bit bad_g = 0, bad_d = 0;
      int d0 = 0, d1 = 0;
      logic [1:0] eg, ed;
      m_l = 2; m_r = 5;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0; bus.req = 2'b11;
      for (int k = 0; k < 27; k++) begin
         @(negedge clk);
         if (k == 26) bus.req = 2'b00;
         eg = ((k % 9) <= 7) ? (((k / 9) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
         ed = ((k % 9) == 7) ? eg : 2'b00;
         if (bus.gnt !== eg) bad_g = 1;
         if (bus.done !== ed) bad_d = 1;
         if (bus.done == 2'b01) d0++;
         if (bus.done == 2'b10) d1++;
      end
      n_cmp++; if (bad_g) begin n_bad++; $display("FAIL tie_gnt: got grant order/gap wrong, required 01,10,01 with done->gnt distance 2"); end
      n_cmp++; if (bad_d) begin n_bad++; $display("FAIL tie_done: got done pulse misplaced, required one pulse per grant"); end
      n_cmp++; if (d0 != 2 || d1 != 1) begin n_bad++;
         $display("FAIL tie_count: got d0=%0d d1=%0d, required 2/1", d0, d1); end
      @(negedge clk);
      last = 1'b0;
   endtask

   task automatic test_random();
      logic [1:0]  r, mode, oh;
      logic [13:0] addr;
      logic [15:0] byt;
      bit w;
      int k;
      for (int it = 0; it < 24; it++) begin
         r = 2'($urandom_range(1, 3));
         mode = 2'($urandom); addr = 14'($urandom); byt = 16'($urandom);
         m_l = $urandom_range(1, 5); m_r = $urandom_range(1, 12); m_rx = 8'($urandom);
         w = (r == 2'b11) ? ~last : r[1];
         oh = w ? 2'b10 : 2'b01;
         bus.req = r; bus.req_mode = mode; bus.req_addr = addr; bus.req_byte = byt;
         for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) begin
               bus.req = 2'b00; bus.req_mode = ~mode; bus.req_addr = ~addr; bus.req_byte = ~byt;
            end
            if (bus.done !== 2'b00) break;
         end
         n_cmp++;
         if (k != int'(m_l + m_r) || bus.done !== oh || bus.gnt !== oh || bus.timeout_err !== 1'b0) begin n_bad++;
            $display("FAIL rand_done it=%0d: got done=%b gnt=%b terr=%b at %0d, required %b at %0d",
                     it, bus.done, bus.gnt, bus.timeout_err, k, oh, m_l + m_r); end
         n_cmp++;
         if (bus.rx_byte !== m_rx || bus.i2c_mode !== mode[w] ||
             bus.i2c_periph_addr !== (w ? addr[13:7] : addr[6:0]) ||
             bus.i2c_transmit_byte !== (w ? byt[15:8] : byt[7:0])) begin n_bad++;
            $display("FAIL rand_fields it=%0d: got rx=%h mode=%b addr=%h tx=%h, required %h/%b/%h/%h",
                     it, bus.rx_byte, bus.i2c_mode, bus.i2c_periph_addr, bus.i2c_transmit_byte,
                     m_rx, mode[w], w ? addr[13:7] : addr[6:0], w ? byt[15:8] : byt[7:0]); end
         @(negedge clk);
         n_cmp++;
         if (bus.gnt !== 2'b00 || bus.done !== 2'b00 || bus.busy !== 1'b0) begin n_bad++;
            $display("FAIL rand_idle it=%0d: got gnt=%b done=%b busy=%b, required 00/00/0",
                     it, bus.gnt, bus.done, bus.busy); end
         last = w;
      end
   endtask

   task automatic test_timeout();
      bit bad_pre = 0;
      tbus.i2c_state = 4'd0;
      tbus.req = 2'b01; tbus.req_mode = 2'b01; tbus.req_addr = 14'h0015; tbus.req_byte = 16'h0099;
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         if (k == 0) tbus.req = 2'b00;
         if (k < 16 && (tbus.i2c_enable !== 1'b1 || tbus.done !== 2'b00 || tbus.timeout_err !== 1'b0 || tbus.busy !== 1'b1))
            bad_pre = 1;
         if (k == 16) begin
            n_cmp++;
            if (tbus.i2c_enable !== 1'b0 || tbus.done !== 2'b01 || tbus.timeout_err !== 1'b1 || tbus.rx_byte !== 8'h00) begin n_bad++;
               $display("FAIL tmo_launch_abort: got en=%b done=%b terr=%b rx=%h, required 0/01/1/00",
                        tbus.i2c_enable, tbus.done, tbus.timeout_err, tbus.rx_byte); end
         end
         if (k == 17) begin
            n_cmp++;
            if (tbus.done !== 2'b00 || tbus.timeout_err !== 1'b0 || tbus.busy !== 1'b0 || tbus.gnt !== 2'b00) begin n_bad++;
               $display("FAIL tmo_launch_idle: got done=%b terr=%b busy=%b gnt=%b, required cleared",
                        tbus.done, tbus.timeout_err, tbus.busy, tbus.gnt); end
         end
      end
      n_cmp++; if (bad_pre) begin n_bad++; $display("FAIL tmo_launch_wait: got early exit/abort, required 16 LAUNCH cycles"); end
      // RUN-phase timeout: controller goes active and never returns.
      bad_pre = 0;
      tbus.req = 2'b10;
      for (int k = 0; k < 21; k++) begin
         @(negedge clk);
         if (k == 0) tbus.req = 2'b00;
         if (k == 2) tbus.i2c_state = 4'd1;
         if (k < 19 && (tbus.done !== 2'b00 || tbus.i2c_enable !== (k < 3))) bad_pre = 1;
         if (k == 19) begin
            n_cmp++;
            if (tbus.done !== 2'b10 || tbus.timeout_err !== 1'b1 || tbus.rx_byte !== 8'h00) begin n_bad++;
               $display("FAIL tmo_run_abort: got done=%b terr=%b rx=%h, required 10/1/00",
                        tbus.done, tbus.timeout_err, tbus.rx_byte); end
            tbus.i2c_state = 4'd0;
         end
         if (k == 20) begin
            n_cmp++;
            if (tbus.busy !== 1'b0 || tbus.timeout_err !== 1'b0 || tbus.gnt !== 2'b00) begin n_bad++;
               $display("FAIL tmo_run_idle: got busy=%b terr=%b gnt=%b, required cleared",
                        tbus.busy, tbus.timeout_err, tbus.gnt); end
         end
      end
      n_cmp++; if (bad_pre) begin n_bad++; $display("FAIL tmo_run_wait: got early done or enable in RUN, required 16 RUN cycles"); end
   endtask

   task automatic test_reset_mid_run();
      // Serve requester 0 first so the tie below goes to requester 1.
      m_l = 1; m_r = 2;
      bus.req = 2'b01;
      @(negedge clk); bus.req = 2'b00;
      repeat (6) @(negedge clk);
      m_l = 2; m_r = 30;
      bus.req = 2'b11;
      repeat (11) @(negedge clk);
      n_cmp++;
      if (bus.gnt !== 2'b10 || bus.busy !== 1'b1) begin n_bad++;
         $display("FAIL midrun_pre: got gnt=%b busy=%b, required 10/1", bus.gnt, bus.busy); end
      reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({bus.gnt, bus.done, bus.rx_byte, bus.timeout_err, bus.busy, bus.i2c_enable,
           bus.i2c_mode, bus.i2c_periph_addr, bus.i2c_transmit_byte} !== 38'd0) begin n_bad++;
         $display("FAIL midrun_reset: got gnt=%b done=%b busy=%b en=%b, required all 0",
                  bus.gnt, bus.done, bus.busy, bus.i2c_enable); end
      reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.gnt !== 2'b01) begin n_bad++;
         $display("FAIL midrun_first_gnt: got %b, required 01", bus.gnt); end
      bus.req = 2'b00;
      repeat (40) @(negedge clk);
      last = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by 200us, required bench to finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.i2c_state = 4'd0;
      bus.i2c_byte_reg = 8'h00;
      test_reset();
      test_single_write();
      test_read();
      test_latching();
      test_tie();
      test_random();
      test_timeout();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
